gbt_rtn_link_arbiter: RTL and testbench
=======================================

// Module: gbt_rtn_link_arbiter
// PURPOSE
//  Round-robin burst arbiter sharing the 16-bit GBT return link between NREQ standard-read FIFO sources
//  (e.g. loopback FIFO, pattern generator, status source). Pops the granted FIFO and registers its words
//  onto DOUT/DVLD, which drive the GBT_RTN_DATA and GBT_TXVD output buffers. Sits in the CLK40 domain,
//  downstream of the FIFO read side. Replaces the single-source readout sequencer.
// PARAMETERS
//  NREQ       3         number of requesters, 2..8
//  MAX_BURST  16        max words popped per grant, 1..255
//  GAP_CYC    2         idle cycles after each burst (pipeline flush), >=2
//  IDLE_WORD  16'hBC50  DOUT value whenever DVLD=0
// PORTS
//  CLK    in   1        40 MHz clock; all logic on posedge
//  RST    in   1        synchronous reset, active-high
//  ENA    in   1        link enable; 0 = no new grants, active burst truncated
//  REQ    in   NREQ     requester has a burst ready (FIFO !prog_empty)
//  MT     in   NREQ     requester FIFO empty
//  DIN    in   NREQ*16  packed FIFO dout; requester i = DIN[16*i+15:16*i]
//  RD_EN  out  NREQ     one-hot FIFO read strobe (at most one bit set)
//  GRANT  out  NREQ     registered one-hot current grant, 0 when not granted
//  DOUT   out  16       registered return-link word
//  DVLD   out  1        DOUT is valid data (drives GBT tx-data-valid)
//  BUSY   out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, GRANT=0, RD_EN=0, DOUT=IDLE_WORD, DVLD=0, BUSY=0, rr pointer=0, burst count=0.
//  Reset mid-burst: in-flight words are dropped, never presented; DVLD=0 in the cycle after RST.
//  FSM states IDLE, (HDR), BURST, GAP.
//   IDLE : if ENA && |REQ: grant first REQ bit at or after ptr (wrapping NREQ-1 -> 0); GRANT registered;
//          ptr <= granted index+1 (mod NREQ); cnt<=0; -> HDR if header enabled, else -> BURST.
//   BURST: RD_EN[g] = (state==BURST) && ENA && !MT[g] && cnt<MAX_BURST (combinational from regs/inputs);
//          cnt increments on every RD_EN. Exit -> GAP when the next pop would be blocked: MT[g] high,
//          cnt reaches MAX_BURST, or ENA=0. A burst issues 0..MAX_BURST pops; 0 pops is legal (MT race).
//   GAP  : GRANT=0, no RD_EN, count GAP_CYC cycles, then -> IDLE.
//  Datapath: RD_EN at cycle n -> DIN valid at n+1 -> DOUT<=DIN[g], DVLD<=1 at n+2 (latency 2).
//   Pipeline carries delayed index with the strobe, so words from a just-closed grant still land correctly
//   during GAP. DVLD=0 cycles output IDLE_WORD.
//  Simultaneous REQ: round robin only; no requester gets two consecutive grants while another REQ is high.
//  REQ dropping during BURST is ignored; MT governs termination. REQ for a non-granted source only waits.
//  ENA=0 in IDLE: stay in IDLE; REQ is not latched.
//  GRANT and RD_EN never have more than one bit set; RD_EN[i] only with GRANT[i].
// CONFIGURATION
//  GBT_ARB_HDR_EN defined: state HDR (1 cycle, no RD_EN) between IDLE and BURST. Presents header word
//   {8'hA5, 4'h0, 4'(g)} with DVLD=1 at the same pipeline latency as data (2 cycles after HDR),
//   i.e. header immediately precedes the first data word of the burst.
//  GBT_ARB_HDR_EN undefined: no HDR state, IDLE -> BURST directly; bursts carry data words only.
// TESTING
//  1 Reset: RST=1 for 3 cycles while REQ=3'b111 -> GRANT=0, RD_EN=0, DVLD=0, DOUT=16'hBC50, BUSY=0.
//  2 Single source: REQ[0]=1, FIFO0 holds 5 words 0x0001..0x0005 -> 5 RD_EN[0] pulses; DOUT 1..5 on 5
//    consecutive cycles with DVLD=1, 2 cycles after each pop; then GAP 2 cycles, IDLE.
//  3 Burst cap: FIFO1 holds 40 words -> exactly 16 pops per grant; bursts of 16,16,8; GAP between bursts.
//  4 Round robin: REQ=3'b111, all FIFOs deep -> grant order 0,1,2,0,...; no consecutive repeat.
//  5 ENA drop: ENA 1->0 after 4 pops of a burst -> RD_EN low the same cycle; exactly 4 DVLD words; no
//    further grant until ENA=1.
//  6 GBT_ARB_HDR_EN: grant to source 2 with 3 words -> DVLD words 0xA502, d0, d1, d2 contiguous.

Source files
------------

// File: rtl/gbt_rtn_link_arbiter_if.sv
// ---------------------------------------------------------------------------
// gbt_rtn_link_arbiter_if
// Bundles the FIFO-side inputs and the return-link outputs of the GBT return
// link arbiter.
//   ena    link enable
//   req    per-source "burst ready" (FIFO !prog_empty)
//   mt     per-source FIFO empty
//   din    packed FIFO read data, source i on din[16*i +: 16]
//   rd_en  one-hot FIFO read strobe
//   grant  registered one-hot grant
//   dout   return-link word, dvld marks it as valid data
//   busy   arbiter not idle
// Modports: master = arbiter side, slave = FIFO/link side.
// ---------------------------------------------------------------------------
interface gbt_rtn_link_arbiter_if #(
    parameter int NREQ = 3
);
    logic                 ena;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      mt;
    logic [NREQ*16-1:0]   din;
    logic [NREQ-1:0]      rd_en;
    logic [NREQ-1:0]      grant;
    logic [15:0]          dout;
    logic                 dvld;
    logic                 busy;

    modport master (
        input  ena, req, mt, din,
        output rd_en, grant, dout, dvld, busy
    );

    modport slave (
        output ena, req, mt, din,
        input  rd_en, grant, dout, dvld, busy
    );
endinterface

// File: rtl/gbt_rtn_link_arbiter.sv
// ---------------------------------------------------------------------------
// gbt_rtn_link_arbiter
// Round-robin burst arbiter sharing the 16-bit GBT return link between NREQ
// standard-read FIFO sources. The granted FIFO is popped for up to MAX_BURST
// words; each word appears on dout/dvld two cycles after its read strobe.
// Every burst is followed by GAP_CYC idle cycles.
//
// Ports:
//   i_clk   40 MHz clock, all logic on rising edge
//   i_rst   synchronous reset, active high
//   link    gbt_rtn_link_arbiter_if.master (ena, req, mt, din in;
//           rd_en, grant, dout, dvld, busy out)
//
// Build option:
//   GBT_ARB_HDR_EN  when defined, each burst is preceded by a one-cycle HDR
//                   state that emits header word {8'hA5, 4'h0, 4'(source)}
//                   directly ahead of the burst's first data word.
// ---------------------------------------------------------------------------
module gbt_rtn_link_arbiter #(
    parameter int          NREQ      = 3,
    parameter int          MAX_BURST = 16,
    parameter int          GAP_CYC   = 2,
    parameter logic [15:0] IDLE_WORD = 16'hBC50
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    gbt_rtn_link_arbiter_if.master        link
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HDR   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]      r_state;
    logic [NREQ-1:0] r_grant;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_ptr;
    logic [7:0]      r_cnt;
    logic [GW-1:0]   r_gap;

    // Stage 1 of the read pipeline: strobe/header marker plus the source
    // index travel together, so a word from a just-closed grant still lands
    // with the right source while the FSM is already in GAP.
    logic            r_p1_vld;
    logic            r_p1_hdr;
    logic [IW-1:0]   r_p1_idx;
    logic [15:0]     r_dout;
    logic            r_dvld;

    logic [15:0]     w_din [NREQ];
    logic [NREQ-1:0] w_rd_en;
    logic            w_pop;
    logic            w_last;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic [IW:0]     w_rr_idx;
    logic [IW-1:0]   w_ptr_next;
    logic            w_hdr_cyc;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_din[gi]   = link.din[16*gi +: 16];
            assign w_rd_en[gi] = w_pop && (r_gidx == IW'(gi));
        end
    endgenerate

    // Pop whenever the granted FIFO has data, the link is enabled and the
    // burst cap is not reached. Reset blocks the strobe so no word leaves a
    // FIFO while the pipeline is being flushed.
    assign w_pop  = !i_rst && (r_state == ST_BURST) && link.ena
                    && !link.mt[r_gidx] && (r_cnt < 8'(MAX_BURST));
    assign w_last = w_pop && (r_cnt == 8'(MAX_BURST - 1));

    assign w_hdr_cyc = (r_state == ST_HDR);

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_rr_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_rr_idx = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_rr_idx >= (IW+1)'(NREQ)) begin
                w_rr_idx = w_rr_idx - (IW+1)'(NREQ);
            end
            if (!w_found && link.req[w_rr_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_rr_idx[IW-1:0];
            end
        end
    end

    assign w_ptr_next = (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_gidx   <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gap    <= '0;
            r_p1_vld <= 1'b0;
            r_p1_hdr <= 1'b0;
            r_p1_idx <= '0;
            r_dout   <= IDLE_WORD;
            r_dvld   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (link.ena && w_found) begin
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
                        r_gidx  <= w_sel;
                        r_ptr   <= w_ptr_next;
                        r_cnt   <= '0;
`ifdef GBT_ARB_HDR_EN
                        r_state <= ST_HDR;
`else
                        r_state <= ST_BURST;
`endif
                    end
                end
                ST_HDR: begin
                    r_state <= ST_BURST;
                end
                ST_BURST: begin
                    if (w_pop) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    // Leave as soon as a cycle goes by without a pop (empty
                    // FIFO or ENA low), or right after the capping pop.
                    if (!w_pop || w_last) begin
                        r_state <= ST_GAP;
                        r_grant <= '0;
                        r_gap   <= '0;
                    end
                end
                default: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
            endcase

            r_p1_vld <= w_pop;
            r_p1_hdr <= w_hdr_cyc;
            r_p1_idx <= r_gidx;

            if (r_p1_vld) begin
                r_dout <= w_din[r_p1_idx];
                r_dvld <= 1'b1;
            end else if (r_p1_hdr) begin
                r_dout <= {8'hA5, 4'h0, 4'(r_p1_idx)};
                r_dvld <= 1'b1;
            end else begin
                r_dout <= IDLE_WORD;
                r_dvld <= 1'b0;
            end
        end
    end

    assign link.rd_en = w_rd_en;
    assign link.grant = r_grant;
    assign link.dout  = r_dout;
    assign link.dvld  = r_dvld;
    assign link.busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gbt_rtn_link_arbiter.sv
`timescale 1ns/1ps
module tb_gbt_rtn_link_arbiter;
    localparam int NREQ = 3;
    localparam int MAXB = 16;
    localparam int GAPC = 2;
`ifdef GBT_ARB_HDR_EN
    localparam int HDR_EXTRA = 1;
`else
    localparam int HDR_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gbt_rtn_link_arbiter_if #(.NREQ(NREQ)) link ();

    gbt_rtn_link_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAXB), .GAP_CYC(GAPC), .IDLE_WORD(16'hBC50)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .link (link)
    );

    // ---------------- FIFO sources (standard read, 1-cycle latency) -------
    logic [15:0]     mem [NREQ][1024];
    int              wp [NREQ] = '{default: 0};
    int              rp [NREQ] = '{default: 0};
    logic [15:0]     din_r [NREQ] = '{default: 16'h0};
    logic [NREQ-1:0] src_en = '0;
    logic [NREQ-1:0] mt_w, req_w;

    always @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (link.rd_en[i] && rp[i] != wp[i]) begin
                din_r[i] <= mem[i][rp[i] % 1024];
                rp[i]    <= rp[i] + 1;
            end
        end
    end

    always_comb begin
        mt_w  = '0;
        req_w = '0;
        for (int i = 0; i < NREQ; i++) begin
            mt_w[i]  = (wp[i] == rp[i]);
            req_w[i] = src_en[i] & ~mt_w[i];
        end
    end
    assign link.mt  = mt_w;
    assign link.req = req_w;
    assign link.din = {din_r[2], din_r[1], din_r[0]};

    // ---------------- monitor -------------------------------------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        mon_on = 1'b0;
    int          popq[$];
    logic [15:0] dlog [2048];
    int          dcyc [2048];
    int          dn = 0;
    logic [15:0] hlog [256];
    int          hcyc [256];
    int          hn = 0;
    int          glog [256];
    int          gs [256];
    int          gn = 0;
    int          blog [256];
    int          ge [256];
    int          bn = 0;
    int          cur_burst = 0;
    int          viol = 0;
    int          lat_err = 0;
    int          pops = 0;
    logic [NREQ-1:0] prev_grant = '0;

    function automatic int oh2idx(input logic [NREQ-1:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) popq.delete();
            if ($isunknown({link.grant, link.rd_en, link.dvld, link.dout, link.busy})
                || !$onehot0(link.grant) || !$onehot0(link.rd_en)
                || ((link.rd_en & ~link.grant) != '0)
                || (!link.dvld && link.dout != 16'hBC50)
                || (link.grant != '0 && !link.busy))
                viol++;
            while (popq.size() > 0 && popq[0] + 2 < cyc) begin
                lat_err++;
                void'(popq.pop_front());
            end
            if (link.dvld) begin
                if (popq.size() > 0 && popq[0] + 2 == cyc) begin
                    dlog[dn] = link.dout; dcyc[dn] = cyc; dn++;
                    void'(popq.pop_front());
                end else begin
                    hlog[hn] = link.dout; hcyc[hn] = cyc; hn++;
                end
            end else if (popq.size() > 0 && popq[0] + 2 == cyc) begin
                lat_err++;
                void'(popq.pop_front());
            end
            if (link.rd_en != '0) begin
                popq.push_back(cyc);
                pops++;
            end
            if (link.grant != '0 && prev_grant == '0) begin
                glog[gn] = oh2idx(link.grant); gs[gn] = cyc; gn++;
                cur_burst = 0;
            end
            if (link.rd_en != '0) cur_burst++;
            if (link.grant == '0 && prev_grant != '0) begin
                blog[bn] = cur_burst; ge[bn] = cyc; bn++;
            end
            prev_grant = link.grant;
        end
    end

    // ---------------- checking helpers -----------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word(input int s, input int k);
        return 16'((s << 12) | (k + 1));
    endfunction

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) mem[s][(wp[s] + k) % 1024] = word(s, k);
        wp[s] = wp[s] + n;
    endtask

    task automatic clear_fifos;
        for (int i = 0; i < NREQ; i++) wp[i] = rp[i];
    endtask

    task automatic wait_done(input string name, input int limit);
        int t;
        t = 0;
        settle;
        while (t < limit && !(link.busy == 1'b0 && mt_w == '1 && popq.size() == 0)) begin
            settle;
            t++;
        end
        check({name, "_timeout"}, 32'(t >= limit), 32'd0);
    endtask

    typedef struct {
        int src;
        int nwords;
        int exp_bursts;
        int exp_last;
        int exp_span;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int b_g, b_b, b_d, b_h, b_v, b_l, b_p, nb, t;
        int rr_len[9];
        int off[NREQ];
        int idx;

        vecs[0] = '{0,  5, 1,  5,  5};
        vecs[1] = '{1, 40, 3,  8, 46};
        vecs[2] = '{2, 16, 1, 16, 16};
        vecs[3] = '{2, 17, 2,  1, 20};
        vecs[4] = '{0,  1, 1,  1,  1};

        link.ena = 1'b1;
        rst      = 1'b1;

        // ---- reset with all requests high ----
        for (int i = 0; i < NREQ; i++) load(i, 4);
        src_en = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            mon_on = 1'b1;
            settle;
            check($sformatf("rst%0d_grant", c), 32'(link.grant), 32'd0);
            check($sformatf("rst%0d_rd_en", c), 32'(link.rd_en), 32'd0);
            check($sformatf("rst%0d_dvld",  c), 32'(link.dvld),  32'd0);
            check($sformatf("rst%0d_dout",  c), 32'(link.dout),  32'h0000BC50);
            check($sformatf("rst%0d_busy",  c), 32'(link.busy),  32'd0);
        end
        src_en = '0;
        clear_fifos();
        @(posedge clk); #1 rst = 1'b0;

        // ---- table: single-source bursts ----
        for (int v = 0; v < 5; v++) begin
            do_reset();
            b_g = gn; b_b = bn; b_d = dn; b_h = hn; b_v = viol; b_l = lat_err;
            load(vecs[v].src, vecs[v].nwords);
            src_en = NREQ'(1 << vecs[v].src);
            wait_done($sformatf("v%0d", v), 1000);
            src_en = '0;
            check($sformatf("v%0d_grants", v), 32'(gn - b_g), 32'(vecs[v].exp_bursts));
            check($sformatf("v%0d_bursts_closed", v), 32'(bn - b_b), 32'(vecs[v].exp_bursts));
            nb = (bn - b_b < vecs[v].exp_bursts) ? bn - b_b : vecs[v].exp_bursts;
            for (int j = 0; j < nb; j++) begin
                check($sformatf("v%0d_grant_src%0d", v, j), 32'(glog[b_g + j]), 32'(vecs[v].src));
                check($sformatf("v%0d_burst_len%0d", v, j), 32'(blog[b_b + j]),
                      32'((j == vecs[v].exp_bursts - 1) ? vecs[v].exp_last : MAXB));
                if (j > 0)
                    check($sformatf("v%0d_gap%0d", v, j), 32'(gs[b_g + j] - ge[b_b + j - 1]), 32'(GAPC + 1));
            end
            check($sformatf("v%0d_words", v), 32'(dn - b_d), 32'(vecs[v].nwords));
            for (int k = 0; k < vecs[v].nwords; k++)
                check($sformatf("v%0d_data%0d", v, k), 32'(dlog[b_d + k]), 32'(word(vecs[v].src, k)));
            check($sformatf("v%0d_span", v), 32'(dcyc[b_d + vecs[v].nwords - 1] - dcyc[b_d] + 1),
                  32'(vecs[v].exp_span + (vecs[v].exp_bursts - 1) * HDR_EXTRA));
            check($sformatf("v%0d_headers", v), 32'(hn - b_h), 32'(vecs[v].exp_bursts * HDR_EXTRA));
            check($sformatf("v%0d_invariants", v), 32'(viol - b_v), 32'd0);
            check($sformatf("v%0d_latency", v), 32'(lat_err - b_l), 32'd0);
            $display("vector %0d: src %0d words %0d grants %0d", v, vecs[v].src, vecs[v].nwords, gn - b_g);
        end

        // ---- round robin, all three sources deep ----
        do_reset();
        b_g = gn; b_b = bn; b_d = dn; b_v = viol; b_l = lat_err;
        for (int i = 0; i < NREQ; i++) load(i, 40);
        src_en = 3'b111;
        wait_done("rr", 3000);
        src_en = '0;
        rr_len = '{16, 16, 16, 16, 16, 16, 8, 8, 8};
        check("rr_grants", 32'(gn - b_g), 32'd9);
        for (int j = 0; j < 9; j++) begin
            check($sformatf("rr_order%0d", j), 32'(glog[b_g + j]), 32'(j % 3));
            check($sformatf("rr_len%0d", j), 32'(blog[b_b + j]), 32'(rr_len[j]));
        end
        check("rr_words", 32'(dn - b_d), 32'd120);
        off = '{default: 0};
        idx = b_d;
        for (int j = 0; j < 9; j++) begin
            for (int k = 0; k < rr_len[j]; k++) begin
                check($sformatf("rr_data%0d", idx - b_d), 32'(dlog[idx]), 32'(word(j % 3, off[j % 3] + k)));
                idx++;
            end
            off[j % 3] += rr_len[j];
        end
        check("rr_invariants", 32'(viol - b_v), 32'd0);
        check("rr_latency", 32'(lat_err - b_l), 32'd0);
        $display("round robin: grants %0d words %0d", gn - b_g, dn - b_d);

        // ---- ENA drop after 4 pops ----
        do_reset();
        b_g = gn; b_b = bn; b_d = dn; b_p = pops; b_v = viol; b_l = lat_err;
        load(0, 10);
        src_en = 3'b001;
        t = 0;
        while (t < 100 && pops - b_p < 4) begin
            settle;
            t++;
        end
        check("ena_pop_timeout", 32'(t >= 100), 32'd0);
        @(posedge clk); #1 link.ena = 1'b0;
        settle;
        check("ena_rd_en_same_cycle", 32'(link.rd_en), 32'd0);
        repeat (20) settle;
        check("ena_pops", 32'(pops - b_p), 32'd4);
        check("ena_words", 32'(dn - b_d), 32'd4);
        check("ena_grants", 32'(gn - b_g), 32'd1);
        check("ena_busy_idle", 32'(link.busy), 32'd0);
        check("ena_grant_idle", 32'(link.grant), 32'd0);
        link.ena = 1'b1;
        wait_done("ena_resume", 500);
        src_en = '0;
        check("ena_resume_grants", 32'(gn - b_g), 32'd2);
        check("ena_burst0", 32'(blog[b_b]), 32'd4);
        check("ena_burst1", 32'(blog[b_b + 1]), 32'd6);
        check("ena_total_words", 32'(dn - b_d), 32'd10);
        for (int k = 0; k < 10; k++)
            check($sformatf("ena_data%0d", k), 32'(dlog[b_d + k]), 32'(word(0, k)));
        check("ena_invariants", 32'(viol - b_v), 32'd0);
        check("ena_latency", 32'(lat_err - b_l), 32'd0);
        $display("ena drop: bursts %0d words %0d", bn - b_b, dn - b_d);

        // ---- reset in the middle of a burst ----
        do_reset();
        b_h = hn; b_p = pops; b_v = viol;
        load(1, 10);
        src_en = 3'b010;
        t = 0;
        while (t < 100 && pops - b_p < 3) begin
            settle;
            t++;
        end
        check("mrst_pop_timeout", 32'(t >= 100), 32'd0);
        src_en = '0;
        rst = 1'b1;
        settle;
        check("mrst_dvld_in_reset", 32'(link.dvld), 32'd0);
        check("mrst_grant", 32'(link.grant), 32'd0);
        check("mrst_busy", 32'(link.busy), 32'd0);
        @(posedge clk); #1;
        clear_fifos();
        rst = 1'b0;
        settle;
        check("mrst_dvld_after", 32'(link.dvld), 32'd0);
        check("mrst_dout_after", 32'(link.dout), 32'h0000BC50);
        repeat (5) settle;
        check("mrst_no_stray_words", 32'(hn - b_h), 32'd0);
        check("mrst_idle", 32'(link.busy), 32'd0);
        check("mrst_invariants", 32'(viol - b_v), 32'd0);
        $display("mid-burst reset: pops before reset %0d", pops - b_p);

`ifdef GBT_ARB_HDR_EN
        // ---- header before data ----
        do_reset();
        b_d = dn; b_h = hn;
        load(2, 3);
        src_en = 3'b100;
        wait_done("hdr", 500);
        src_en = '0;
        check("hdr_count", 32'(hn - b_h), 32'd1);
        check("hdr_word", 32'(hlog[b_h]), 32'h0000A502);
        check("hdr_words", 32'(dn - b_d), 32'd3);
        check("hdr_contig", 32'(dcyc[b_d] - hcyc[b_h]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hdr_data%0d", k), 32'(dlog[b_d + k]), 32'(word(2, k)));
            check($sformatf("hdr_cyc%0d", k), 32'(dcyc[b_d + k] - hcyc[b_h]), 32'(k + 1));
        end
        $display("header: %0h then %0d words", hlog[b_h], dn - b_d);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
